// File: rtl/sprite_pixel_drawer.sv
// Composites a 40x30 ROM sprite over the background; fixed 2-cycle latency, no stalls.
// Position writes are held pending and applied only on frame_tick so a frame never tears.
module sprite_pixel_drawer #(
  parameter int          SPR_W      = 40,
  parameter int          SPR_H      = 30,
  parameter int          SCALE_LOG2 = 0,
  parameter logic [11:0] TRANSP     = 12'hfff,
  parameter bit          TRANSP_EN  = 1'b1,
  parameter int          INIT_X     = 300,
  parameter int          INIT_Y     = 220
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic                  video_on,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  frame_tick,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic                  pos_wr,
  input  logic [11:0]           bg_rgb,
  output logic [4:0]            rom_row,
  input  logic [SPR_W*12-1:0]   rom_rgb,
  output logic [11:0]           rgb_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  video_on_out
);

  localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);
  localparam int          BW    = $clog2(SPR_W * 12);

  logic [9:0]  cur_x_q, cur_y_q, cur_x_d, cur_y_d;
  logic [9:0]  pend_x_q, pend_y_q, pend_x_d, pend_y_d;
  logic        pend_vld_q, pend_vld_d;

  logic        in_box1_q, in_box1_d;
  logic [5:0]  col1_q, col1_d;
  logic [4:0]  row1_q, row1_d;
  logic        vid1_q, hs1_q, vs1_q;
  logic [11:0] bg1_q;

  logic [11:0] rgb2_q, rgb2_d;
  logic        vid2_q, hs2_q, vs2_q;

  logic [10:0]   dx, dy;
  logic [BW-1:0] pix_base;
  logic [11:0]   pix;

  // A write coinciding with the tick bypasses the pending register entirely.
  always_comb begin
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    pend_vld_d = pend_vld_q;
    if (pos_wr) begin
      pend_x_d = pos_x;
      pend_y_d = pos_y;
    end
    if (frame_tick && pos_wr) begin
      cur_x_d    = pos_x;
      cur_y_d    = pos_y;
      pend_vld_d = 1'b0;
    end else if (frame_tick && pend_vld_q) begin
      cur_x_d    = pend_x_q;
      cur_y_d    = pend_y_q;
      pend_vld_d = 1'b0;
    end else if (pos_wr) begin
      pend_vld_d = 1'b1;
    end
  end

  always_comb begin
    dx        = {1'b0, pixel_x} - {1'b0, cur_x_q};
    dy        = {1'b0, pixel_y} - {1'b0, cur_y_q};
    in_box1_d = video_on && !dx[10] && (dx < BOX_W) && !dy[10] && (dy < BOX_H);
    col1_d    = '0;
    row1_d    = '0;
    if (in_box1_d) begin
      col1_d = 6'(dx >> SCALE_LOG2);
      row1_d = 5'(dy >> SCALE_LOG2);
    end
  end

  // col1 is forced to 0 outside the box, so the select base never exceeds the row width.
  always_comb begin
    pix_base = BW'(12 * (SPR_W - 1 - int'(col1_q)));
    pix      = rom_rgb[pix_base +: 12];
    rgb2_d   = '0;
    if (vid1_q) begin
      if (!in_box1_q || (TRANSP_EN && (pix == TRANSP))) rgb2_d = bg1_q;
      else                                              rgb2_d = pix;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_x_q    <= 10'(INIT_X);
      cur_y_q    <= 10'(INIT_Y);
      pend_x_q   <= 10'(INIT_X);
      pend_y_q   <= 10'(INIT_Y);
      pend_vld_q <= 1'b0;
      in_box1_q  <= 1'b0;
      col1_q     <= '0;
      row1_q     <= '0;
      vid1_q     <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      bg1_q      <= '0;
      rgb2_q     <= '0;
      vid2_q     <= 1'b0;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
    end else begin
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pend_vld_q <= pend_vld_d;
      in_box1_q  <= in_box1_d;
      col1_q     <= col1_d;
      row1_q     <= row1_d;
      vid1_q     <= video_on;
      hs1_q      <= hsync_in;
      vs1_q      <= vsync_in;
      bg1_q      <= bg_rgb;
      rgb2_q     <= rgb2_d;
      vid2_q     <= vid1_q;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
    end
  end

  assign rom_row      = row1_q;
  assign rgb_out      = rgb2_q;
  assign hsync_out    = hs2_q;
  assign vsync_out    = vs2_q;
  assign video_on_out = vid2_q;

endmodule

// File: tb/tb_sprite_pixel_drawer.sv
// Random and directed stimulus for three sprite drawer variants (default, 2x scale, no
// transparency), checked against a per-pixel reference model of the compositing rules.
module tb_sprite_pixel_drawer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pixel_x = '0, pixel_y = '0, pos_x = '0, pos_y = '0;
  logic        video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, frame_tick = 1'b0, pos_wr = 1'b0;
  logic [11:0] bg_rgb = '0;

  logic [4:0]   rom_row   [3];
  logic [479:0] rom_rgb   [3];
  logic [11:0]  rgb_out   [3];
  logic         hsync_out [3];
  logic         vsync_out [3];
  logic         vid_out   [3];

  logic [479:0] rom_mem [32];

  int n_cmp = 0;
  int n_mis = 0;

  localparam int SC [3] = '{0, 1, 0};
  localparam bit TE [3] = '{1'b1, 1'b1, 1'b0};

  typedef struct packed {
    logic [2:0][11:0] rgb;
    logic [2:0][4:0]  row;
    logic             hs;
    logic             vs;
    logic             vid;
  } exp_t;

  exp_t p1, p2;
  int   m_cx, m_cy, m_px, m_py;
  bit   m_pv;

  always #5 clk = ~clk;

  assign rom_rgb[0] = rom_mem[rom_row[0]];
  assign rom_rgb[1] = rom_mem[rom_row[1]];
  assign rom_rgb[2] = rom_mem[rom_row[2]];

  sprite_pixel_drawer u_dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_tick(frame_tick), .pos_x(pos_x),
    .pos_y(pos_y), .pos_wr(pos_wr), .bg_rgb(bg_rgb), .rom_row(rom_row[0]), .rom_rgb(rom_rgb[0]),
    .rgb_out(rgb_out[0]), .hsync_out(hsync_out[0]), .vsync_out(vsync_out[0]),
    .video_on_out(vid_out[0]));

  sprite_pixel_drawer #(.SCALE_LOG2(1)) u_dut_s1 (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_tick(frame_tick), .pos_x(pos_x),
    .pos_y(pos_y), .pos_wr(pos_wr), .bg_rgb(bg_rgb), .rom_row(rom_row[1]), .rom_rgb(rom_rgb[1]),
    .rgb_out(rgb_out[1]), .hsync_out(hsync_out[1]), .vsync_out(vsync_out[1]),
    .video_on_out(vid_out[1]));

  sprite_pixel_drawer #(.TRANSP_EN(1'b0)) u_dut_nt (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_tick(frame_tick), .pos_x(pos_x),
    .pos_y(pos_y), .pos_wr(pos_wr), .bg_rgb(bg_rgb), .rom_row(rom_row[2]), .rom_rgb(rom_rgb[2]),
    .rgb_out(rgb_out[2]), .hsync_out(hsync_out[2]), .vsync_out(vsync_out[2]),
    .video_on_out(vid_out[2]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // What the screen should show at (x,y) for a sprite whose top-left is (cx,cy).
  function automatic void ref_pix(input int x, input int y, input bit vid, input logic [11:0] bg,
                                  input int cx, input int cy, input int s, input bit ten,
                                  output logic [11:0] rgb, output logic [4:0] row);
    int sx, sy, c, r;
    logic [11:0] p;
    sx  = x - cx;
    sy  = y - cy;
    rgb = '0;
    row = '0;
    if (!vid) return;
    if (sx < 0 || sx >= (40 << s) || sy < 0 || sy >= (30 << s)) begin
      rgb = bg;
      return;
    end
    c   = sx >> s;
    r   = sy >> s;
    row = 5'(r);
    p   = rom_mem[r][479 - 12*c -: 12];
    rgb = (ten && p == 12'hfff) ? bg : p;
  endfunction

  task automatic model_reset();
    m_cx = 300; m_cy = 220; m_px = 300; m_py = 220; m_pv = 1'b0;
    p1 = '0;
    p2 = '0;
  endtask

  // Drive one pixel at a negedge, advance the reference, then check at the next negedge.
  task automatic step(input int x, input int y, input bit vid, input bit wr, input int px,
                      input int py, input bit ft);
    exp_t e;
    pixel_x    = 10'(x);
    pixel_y    = 10'(y);
    video_on   = vid;
    hsync_in   = 1'($urandom_range(0, 1));
    vsync_in   = 1'($urandom_range(0, 1));
    bg_rgb     = 12'($urandom_range(0, 4095));
    pos_wr     = wr;
    pos_x      = 10'(px);
    pos_y      = 10'(py);
    frame_tick = ft;
    e     = '0;
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    e.vid = vid;
    for (int i = 0; i < 3; i++)
      ref_pix(int'(pixel_x), int'(pixel_y), vid, bg_rgb, m_cx, m_cy, SC[i], TE[i],
              e.rgb[i], e.row[i]);
    p2 = p1;
    p1 = e;
    if (wr && ft) begin
      m_cx = int'(pos_x); m_cy = int'(pos_y); m_px = m_cx; m_py = m_cy; m_pv = 1'b0;
    end else if (ft && m_pv) begin
      m_cx = m_px; m_cy = m_py; m_pv = 1'b0;
    end else if (wr) begin
      m_px = int'(pos_x); m_py = int'(pos_y); m_pv = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rom_row[%0d]", i), 32'(rom_row[i]), 32'(p1.row[i]));
      check_eq($sformatf("rgb_out[%0d]", i), 32'(rgb_out[i]), 32'(p2.rgb[i]));
      check_eq($sformatf("hsync_out[%0d]", i), 32'(hsync_out[i]), 32'(p2.hs));
      check_eq($sformatf("vsync_out[%0d]", i), 32'(vsync_out[i]), 32'(p2.vs));
      check_eq($sformatf("video_on_out[%0d]", i), 32'(vid_out[i]), 32'(p2.vid));
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s rom_row[%0d]", tag, i), 32'(rom_row[i]), 32'd0);
      check_eq($sformatf("%s rgb_out[%0d]", tag, i), 32'(rgb_out[i]), 32'd0);
      check_eq($sformatf("%s hsync[%0d]", tag, i), 32'(hsync_out[i]), 32'd0);
      check_eq($sformatf("%s vsync[%0d]", tag, i), 32'(vsync_out[i]), 32'd0);
      check_eq($sformatf("%s video_on[%0d]", tag, i), 32'(vid_out[i]), 32'd0);
    end
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic rand_near(input int n, input int span_x, input int span_y, input int wr_odds,
                           input int ft_odds);
    for (int k = 0; k < n; k++) begin
      bit wr, ft;
      wr = (wr_odds != 0) && ($urandom_range(0, wr_odds - 1) == 0);
      ft = (ft_odds != 0) && ($urandom_range(0, ft_odds - 1) == 0);
      step(m_cx + int'($urandom_range(0, span_x)) - 8, m_cy + int'($urandom_range(0, span_y)) - 8,
           $urandom_range(0, 9) != 0, wr, int'($urandom_range(0, 639)),
           int'($urandom_range(0, 479)), ft);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      rom_mem[r] = '0;
      if (r < 30)
        for (int c = 0; c < 40; c++)
          rom_mem[r][479 - 12*c -: 12] = ($urandom_range(0, 7) == 0) ? 12'hfff
                                                                      : 12'($urandom_range(0, 4094));
    end
    rom_mem[3][479:468] = 12'h0bc;
    rom_mem[3][11:0]    = 12'h5a7;
    rom_mem[5][467:456] = 12'hfff;
    model_reset();

    #2 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Sprite at its reset position, then a reset landing mid-line over the sprite.
    rand_near(300, 100, 50, 0, 0);
    step(305, 225, 1'b1, 1'b0, 0, 0, 1'b0);
    mid_reset();
    rand_near(200, 100, 50, 0, 0);

    // Move to (100,50) with a same-cycle tick; hit both edge columns and the box borders.
    step(0, 0, 1'b0, 1'b1, 100, 50, 1'b1);
    step(100, 53, 1'b1, 1'b0, 0, 0, 1'b0);
    step(139, 53, 1'b1, 1'b0, 0, 0, 1'b0);
    step(99, 53, 1'b1, 1'b0, 0, 0, 1'b0);
    step(140, 53, 1'b1, 1'b0, 0, 0, 1'b0);
    step(101, 55, 1'b1, 1'b0, 0, 0, 1'b0);
    step(100, 53, 1'b0, 1'b0, 0, 0, 1'b0);
    step(100, 49, 1'b1, 1'b0, 0, 0, 1'b0);
    step(100, 80, 1'b1, 1'b0, 0, 0, 1'b0);

    // Pending writes: two writes then a tick, and a write that must wait for its tick.
    step(110, 60, 1'b1, 1'b1, 200, 100, 1'b0);
    step(110, 60, 1'b1, 1'b1, 210, 110, 1'b0);
    rand_near(40, 60, 40, 0, 0);
    step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    rand_near(60, 100, 70, 0, 0);

    // Clipped at the bottom-right corner of the screen.
    step(0, 0, 1'b0, 1'b1, 620, 470, 1'b1);
    for (int k = 0; k < 300; k++)
      step(600 + int'($urandom_range(0, 45)), 462 + int'($urandom_range(0, 20)),
           $urandom_range(0, 9) != 0, 1'b0, 0, 0, 1'b0);

    // Origin placement, where the 2x instance covers 80x60 pixels.
    step(0, 0, 1'b0, 1'b1, 0, 0, 1'b1);
    step(3, 5, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int k = 0; k < 600; k++)
      step(int'($urandom_range(0, 90)), int'($urandom_range(0, 70)),
           $urandom_range(0, 9) != 0, 1'b0, 0, 0, 1'b0);

    // Random position traffic with occasional ticks.
    rand_near(1500, 100, 60, 40, 60);
    step(m_cx + 2, m_cy + 2, 1'b1, 1'b0, 0, 0, 1'b0);
    mid_reset();
    rand_near(200, 100, 50, 30, 50);
    step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
